// File: rtl/elelock_pkg.sv
// -----------------------------------------------------------------------------
// elelock_pkg
// Shared types and constants for the parametrised electronic lock.
//   state_t   : lock FSM states (LOCKED, UNLOCKED, PROG, LOCKOUT)
//   DIGIT_W   : width of one BCD digit in the entry buffer / secret
//   KEY_EMPTY : filler nibble marking an unused buffer position
//   KEYS      : number of keys on the one-hot ten-key pad
// -----------------------------------------------------------------------------
package elelock_pkg;

   localparam int          DIGIT_W   = 4;
   localparam logic [3:0]  KEY_EMPTY = 4'hF;
   localparam int          KEYS      = 10;

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_UNLOCKED = 2'd1,
      ST_PROG     = 2'd2,
      ST_LOCKOUT  = 2'd3
   } state_t;

endpackage

// File: rtl/elelock_keyenc.sv
// -----------------------------------------------------------------------------
// elelock_keyenc
// Turns the debounced one-hot keypad into single-cycle digit events.
// Ports:
//   clk, reset_n : clock / asynchronous active-low reset
//   tenkey[9:0]  : one-hot keypad, bit n = digit n, all-zero = no key
//   digit[3:0]   : encoded digit of the key currently pressed
//   press        : 1 for one cycle when exactly one key goes down from idle
//   invalid      : more than one key is down this cycle
// A held key, or a key that follows another without an idle cycle between,
// produces no press because the previous sample is not all-zero.
// -----------------------------------------------------------------------------
module elelock_keyenc
   import elelock_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [KEYS-1:0]    tenkey,
   output logic [DIGIT_W-1:0] digit,
   output logic               press,
   output logic               invalid
);

   logic [KEYS-1:0]    prev_q, prev_d;
   logic [3:0]         ones;
   logic [DIGIT_W-1:0] digit_c;

   always_comb begin
      prev_d  = tenkey;
      ones    = '0;
      digit_c = '0;
      for (int i = 0; i < KEYS; i++) begin
         if (tenkey[i]) begin
            ones    = ones + 4'd1;
            digit_c = DIGIT_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev_q <= '0;
      else          prev_q <= prev_d;
   end

   assign digit   = digit_c;
   assign press   = (ones == 4'd1) && (prev_q == '0);
   assign invalid = (ones > 4'd1);

endmodule

// File: rtl/param_elelock.sv
// -----------------------------------------------------------------------------
// param_elelock
// Parametrised electronic door lock with failed-attempt lockout and
// re-programmable secret.
// Ports:
//   clk, reset_n : clock / asynchronous active-low reset
//   tenkey[9:0]  : one-hot keypad from the debouncer
//   enter        : strobe, evaluate the entered digits
//   close        : level, relock (UNLOCKED) / abort (PROG, LOCKED entry)
//   set_mode     : strobe, start programming a new secret (UNLOCKED only)
//   lock         : 1 = door locked
//   alarm        : 1 while in lockout
//   fail_cnt[3:0]: consecutive wrong entries, saturating at MAX_FAIL
//   prog_active  : 1 while programming
//   dbg_state    : current FSM state, for observation only
// Handshake: enter and set_mode are fire-and-forget single-cycle strobes with
// no ready/ack; a strobe that arrives in a state that does not use it is
// dropped. close is a level and wins over any strobe in the same cycle.
// Optional build macro: PARAM_ELELOCK_AUTO_RELOCK_EN adds an idle counter
// that relocks the door after RELOCK_CYCLES quiet cycles in UNLOCKED.
// -----------------------------------------------------------------------------
module param_elelock
   import elelock_pkg::*;
#(
   parameter int                            CODE_LEN       = 4,
   parameter logic [DIGIT_W*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h3695,
   parameter int                            MAX_FAIL       = 3,
   parameter int                            LOCKOUT_CYCLES = 1024,
   parameter int                            RELOCK_CYCLES  = 4096
)
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic [KEYS-1:0] tenkey,
   input  logic            enter,
   input  logic            close,
   input  logic            set_mode,
   output logic            lock,
   output logic            alarm,
   output logic [3:0]      fail_cnt,
   output logic            prog_active,
   output state_t          dbg_state
);

   localparam int                BUF_W     = DIGIT_W * CODE_LEN;
   localparam int                TMR_W     = $clog2(LOCKOUT_CYCLES);
   localparam logic [BUF_W-1:0]  EMPTY_BUF = {CODE_LEN{KEY_EMPTY}};

   // A buffer position still holding the filler nibble means the entry is
   // incomplete; such a buffer may neither match nor become the secret.
   function automatic logic has_empty(input logic [BUF_W-1:0] b);
      logic e;
      e = 1'b0;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (b[i*DIGIT_W +: DIGIT_W] == KEY_EMPTY) e = 1'b1;
      end
      return e;
   endfunction

   logic [DIGIT_W-1:0] key_digit;
   logic               key_press, key_invalid, key_edge;

   elelock_keyenc u_keyenc (
      .clk     (clk),
      .reset_n (reset_n),
      .tenkey  (tenkey),
      .digit   (key_digit),
      .press   (key_press),
      .invalid (key_invalid)
   );

   assign key_edge = key_press & ~key_invalid;

   state_t           state_q, state_d;
   logic [BUF_W-1:0] buf_q, buf_d;
   logic [BUF_W-1:0] secret_q, secret_d;
   logic [3:0]       fail_q, fail_d, fail_next;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             lock_q, lock_d;
   logic             alarm_q, alarm_d;
   logic             prog_q, prog_d;
   logic             match;
   logic [BUF_W-1:0] buf_shift;

`ifdef PARAM_ELELOCK_AUTO_RELOCK_EN
   localparam int     IDLE_W = $clog2(RELOCK_CYCLES);
   logic [IDLE_W-1:0] idle_q, idle_d;
`endif

   assign match     = (buf_q == secret_q) && !has_empty(buf_q);
   assign buf_shift = {buf_q[BUF_W-DIGIT_W-1:0], key_digit};
   assign fail_next = (fail_q >= 4'(MAX_FAIL)) ? fail_q : fail_q + 4'd1;

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      secret_d = secret_q;
      fail_d   = fail_q;
      timer_d  = timer_q;
      lock_d   = lock_q;
      alarm_d  = alarm_q;
      prog_d   = prog_q;
`ifdef PARAM_ELELOCK_AUTO_RELOCK_EN
      idle_d   = idle_q;
`endif
      case (state_q)
         ST_LOCKED: begin
            if (close) begin
               // Abort a partial entry; a concurrent enter is discarded.
               buf_d = EMPTY_BUF;
            end else if (enter) begin
               // Any press edge this cycle is dropped: enter sees the
               // pre-shift buffer.
               buf_d = EMPTY_BUF;
               if (match) begin
                  state_d = ST_UNLOCKED;
                  lock_d  = 1'b0;
                  fail_d  = '0;
`ifdef PARAM_ELELOCK_AUTO_RELOCK_EN
                  idle_d  = '0;
`endif
               end else begin
                  fail_d = fail_next;
                  if (fail_next == 4'(MAX_FAIL)) begin
                     state_d = ST_LOCKOUT;
                     alarm_d = 1'b1;
                     timer_d = TMR_W'(LOCKOUT_CYCLES - 1);
                  end
               end
            end else if (key_edge) begin
               buf_d = buf_shift;
            end
         end
         ST_LOCKOUT: begin
            // Loaded with LOCKOUT_CYCLES-1, the extra exit cycle at zero
            // makes the alarm last exactly LOCKOUT_CYCLES cycles.
            if (timer_q == '0) begin
               state_d = ST_LOCKED;
               alarm_d = 1'b0;
               fail_d  = '0;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_UNLOCKED: begin
            if (close) begin
               state_d = ST_LOCKED;
               lock_d  = 1'b1;
            end else if (set_mode) begin
               state_d = ST_PROG;
               prog_d  = 1'b1;
               buf_d   = EMPTY_BUF;
            end else begin
`ifdef PARAM_ELELOCK_AUTO_RELOCK_EN
               if (key_edge || enter) begin
                  idle_d = '0;
               end else if (idle_q == IDLE_W'(RELOCK_CYCLES - 1)) begin
                  state_d = ST_LOCKED;
                  lock_d  = 1'b1;
               end else begin
                  idle_d = idle_q + IDLE_W'(1);
               end
`endif
            end
         end
         ST_PROG: begin
            if (close) begin
               state_d = ST_LOCKED;
               lock_d  = 1'b1;
               prog_d  = 1'b0;
               buf_d   = EMPTY_BUF;
            end else if (enter) begin
               if (!has_empty(buf_q)) secret_d = buf_q;
               state_d = ST_UNLOCKED;
               prog_d  = 1'b0;
               buf_d   = EMPTY_BUF;
`ifdef PARAM_ELELOCK_AUTO_RELOCK_EN
               idle_d  = '0;
`endif
            end else if (key_edge) begin
               buf_d = buf_shift;
            end
         end
         default: begin
            state_d = ST_LOCKED;
            lock_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_LOCKED;
         buf_q    <= EMPTY_BUF;
         secret_q <= DEFAULT_CODE;
         fail_q   <= '0;
         timer_q  <= '0;
         lock_q   <= 1'b1;
         alarm_q  <= 1'b0;
         prog_q   <= 1'b0;
`ifdef PARAM_ELELOCK_AUTO_RELOCK_EN
         idle_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         secret_q <= secret_d;
         fail_q   <= fail_d;
         timer_q  <= timer_d;
         lock_q   <= lock_d;
         alarm_q  <= alarm_d;
         prog_q   <= prog_d;
`ifdef PARAM_ELELOCK_AUTO_RELOCK_EN
         idle_q   <= idle_d;
`endif
      end
   end

   assign lock        = lock_q;
   assign alarm       = alarm_q;
   assign fail_cnt    = fail_q;
   assign prog_active = prog_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_param_elelock.sv
// -----------------------------------------------------------------------------
// tb_param_elelock
// Directed bench for param_elelock. A reference model keeps the entered
// digits as a queue and the secret as a digit array, and is stepped on every
// clock edge; a compare process checks all outputs against it on every
// falling edge. Hand-computed literal checks pin the model along the way.
// -----------------------------------------------------------------------------
module tb_param_elelock;
   import elelock_pkg::*;

   localparam int          CODE_LEN = 4;
   localparam logic [15:0] DEF_CODE = 16'h3695;
   localparam int          MAX_FAIL = 3;
   localparam int          LOCKOUT  = 1024;
   localparam int          RELOCK   = 16;

   localparam int MD_LOCKED   = 0;
   localparam int MD_UNLOCKED = 1;
   localparam int MD_PROG     = 2;
   localparam int MD_LOCKOUT  = 3;

   // ---------------- clock / reset ----------------
   logic       clk      = 1'b0;
   logic       reset_n  = 1'b1;
   logic [9:0] tenkey   = '0;
   logic       enter    = 1'b0;
   logic       close    = 1'b0;
   logic       set_mode = 1'b0;
   logic       lock, alarm, prog_active;
   logic [3:0] fail_cnt;
   state_t     dbg_state;

   always #5 clk = ~clk;

   param_elelock #(
      .CODE_LEN       (CODE_LEN),
      .DEFAULT_CODE   (DEF_CODE),
      .MAX_FAIL       (MAX_FAIL),
      .LOCKOUT_CYCLES (LOCKOUT),
      .RELOCK_CYCLES  (RELOCK)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tenkey      (tenkey),
      .enter       (enter),
      .close       (close),
      .set_mode    (set_mode),
      .lock        (lock),
      .alarm       (alarm),
      .fail_cnt    (fail_cnt),
      .prog_active (prog_active),
      .dbg_state   (dbg_state)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_mode, m_fail, m_left, m_idle;
   int         m_q[$];
   int         m_sec[CODE_LEN];
   logic [9:0] m_prev;

   task automatic model_reset();
      m_mode = MD_LOCKED;
      m_fail = 0;
      m_left = 0;
      m_idle = 0;
      m_q.delete();
      m_prev = '0;
      for (int i = 0; i < CODE_LEN; i++)
         m_sec[i] = int'((DEF_CODE >> (4 * (CODE_LEN - 1 - i))) & 16'hF);
   endtask

   task automatic model_push(input int d);
      m_q.push_back(d);
      if (m_q.size() > CODE_LEN) void'(m_q.pop_front());
   endtask

   task automatic model_step(input logic [9:0] tk, input logic en,
                             input logic cl, input logic sm);
      bit ev, hit;
      int dig;
      ev  = ($countones(tk) == 1) && (m_prev == '0);
      dig = 0;
      for (int i = 0; i < 10; i++) if (tk[i]) dig = i;
      m_prev = tk;
      hit = (m_q.size() == CODE_LEN);
      if (hit) for (int i = 0; i < CODE_LEN; i++) if (m_q[i] != m_sec[i]) hit = 0;
      case (m_mode)
         MD_LOCKED: begin
            if (cl) m_q.delete();
            else if (en) begin
               m_q.delete();
               if (hit) begin
                  m_mode = MD_UNLOCKED;
                  m_fail = 0;
                  m_idle = 0;
               end else begin
                  if (m_fail < MAX_FAIL) m_fail++;
                  if (m_fail == MAX_FAIL) begin
                     m_mode = MD_LOCKOUT;
                     m_left = LOCKOUT;
                  end
               end
            end else if (ev) model_push(dig);
         end
         MD_LOCKOUT: begin
            m_left--;
            if (m_left == 0) begin
               m_mode = MD_LOCKED;
               m_fail = 0;
            end
         end
         MD_UNLOCKED: begin
            if (cl) m_mode = MD_LOCKED;
            else if (sm) begin
               m_mode = MD_PROG;
               m_q.delete();
            end else begin
`ifdef PARAM_ELELOCK_AUTO_RELOCK_EN
               if (ev || en) m_idle = 0;
               else begin
                  m_idle++;
                  if (m_idle == RELOCK) m_mode = MD_LOCKED;
               end
`endif
            end
         end
         default: begin // MD_PROG
            if (cl) begin
               m_mode = MD_LOCKED;
               m_q.delete();
            end else if (en) begin
               if (m_q.size() == CODE_LEN)
                  for (int i = 0; i < CODE_LEN; i++) m_sec[i] = m_q[i];
               m_q.delete();
               m_mode = MD_UNLOCKED;
               m_idle = 0;
            end else if (ev) model_push(dig);
         end
      endcase
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else          model_step(tenkey, enter, close, set_mode);
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      check("lock",        int'(lock),        (m_mode == MD_LOCKED || m_mode == MD_LOCKOUT) ? 1 : 0);
      check("alarm",       int'(alarm),       (m_mode == MD_LOCKOUT) ? 1 : 0);
      check("fail_cnt",    int'(fail_cnt),    m_fail);
      check("prog_active", int'(prog_active), (m_mode == MD_PROG) ? 1 : 0);
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int d);
      tenkey = 10'(1 << d);
      tick(1);
      tenkey = '0;
      tick(1);
   endtask

   task automatic press4(input int a, input int b, input int c, input int d);
      press(a); press(b); press(c); press(d);
   endtask

   task automatic pulse_enter();
      enter = 1'b1; tick(1); enter = 1'b0;
   endtask

   task automatic pulse_close();
      close = 1'b1; tick(1); close = 1'b0;
   endtask

   task automatic pulse_set();
      set_mode = 1'b1; tick(1); set_mode = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      #1 reset_n = 1'b0;
      tick(1);
      check("rst_lock", int'(lock), 1);
      check("rst_alarm", int'(alarm), 0);
      check("rst_fail", int'(fail_cnt), 0);
      check("rst_prog", int'(prog_active), 0);
      reset_n = 1'b1;
      tick(1);

      // Default code unlocks one cycle after enter.
      press4(3, 6, 9, 5);
      check("pre_enter_lock", int'(lock), 1);
      enter = 1'b1; tick(1); enter = 1'b0;
      check("unlock_lock", int'(lock), 0);
      check("unlock_fail", int'(fail_cnt), 0);
      check("model_unlocked", m_mode, MD_UNLOCKED);
      pulse_close();
      check("close_lock", int'(lock), 1);

      // Three wrong entries -> lockout.
      for (int k = 1; k <= 3; k++) begin
         press4(1, 2, 3, 4);
         pulse_enter();
         if (k < 3) begin
            check("wrong_fail", int'(fail_cnt), k);
            check("wrong_alarm", int'(alarm), 0);
         end else begin
            check("lockout_alarm", int'(alarm), 1);
            check("lockout_fail", int'(fail_cnt), 3);
            check("model_fail", m_fail, 3);
         end
      end
      // Correct code inside lockout is ignored (9 cycles).
      press4(3, 6, 9, 5);
      pulse_enter();
      check("lockout_ignores_code", int'(lock), 1);
      tick(LOCKOUT - 1 - 9);
      check("alarm_last_cycle", int'(alarm), 1);
      tick(1);
      check("lockout_end_alarm", int'(alarm), 0);
      check("lockout_end_lock", int'(lock), 1);
      check("lockout_end_fail", int'(fail_cnt), 0);

      // Re-program the secret to 7701.
      press4(3, 6, 9, 5); pulse_enter();
      pulse_set();
      check("prog_on", int'(prog_active), 1);
      press4(7, 7, 0, 1); pulse_enter();
      check("prog_off", int'(prog_active), 0);
      check("prog_unlocked", int'(lock), 0);
      pulse_close();
      check("prog_close", int'(lock), 1);
      press4(7, 7, 0, 1); pulse_enter();
      check("new_code_unlocks", int'(lock), 0);
      pulse_close();
      press4(3, 6, 9, 5); pulse_enter();
      check("old_code_fails", int'(lock), 1);
      check("old_code_fail_cnt", int'(fail_cnt), 1);

      // Multi-hot gives no digit; a 5-cycle hold gives exactly one.
      press(7); press(7); press(0);
      tenkey = 10'b0000001010; tick(1);
      tenkey = '0; tick(1);
      tenkey = 10'b0000000010; tick(5);
      tenkey = '0; tick(1);
      pulse_enter();
      check("hold_one_digit", int'(lock), 0);
      check("hold_fail_clear", int'(fail_cnt), 0);

      // close beats enter while unlocked.
      enter = 1'b1; close = 1'b1; tick(1);
      enter = 1'b0; close = 1'b0;
      check("close_beats_enter", int'(lock), 1);
      // Last digit pressed together with enter is discarded.
      press(7); press(7); press(0);
      tenkey = 10'b0000000010; enter = 1'b1; tick(1);
      tenkey = '0; enter = 1'b0; tick(1);
      check("preshift_fails", int'(lock), 1);
      check("preshift_fail_cnt", int'(fail_cnt), 1);
      // Full code, then enter with an extra press: still matches.
      press4(7, 7, 0, 1);
      tenkey = 10'b0000100000; enter = 1'b1; tick(1);
      tenkey = '0; enter = 1'b0;
      check("extra_press_ignored", int'(lock), 0);

      // Idle behaviour in UNLOCKED.
`ifdef PARAM_ELELOCK_AUTO_RELOCK_EN
      tick(RELOCK - 1);
      check("relock_not_yet", int'(lock), 0);
      tick(1);
      check("relock_fired", int'(lock), 1);
`else
      tick(40);
      check("no_auto_relock", int'(lock), 0);
`endif
      pulse_close();

      // PROG with an incomplete entry keeps the secret.
      press4(7, 7, 0, 1); pulse_enter();
      pulse_set();
      press(1); press(2); pulse_enter();
      check("short_prog_off", int'(prog_active), 0);
      check("short_prog_unlocked", int'(lock), 0);
      pulse_close();
      press4(7, 7, 0, 1); pulse_enter();
      check("secret_kept", int'(lock), 0);

      // Reset mid-PROG restores the default secret.
      pulse_set();
      check("prog_again", int'(prog_active), 1);
      press(1); press(2); press(3);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_prog", int'(prog_active), 0);
      check("async_rst_lock", int'(lock), 1);
      tick(1);
      reset_n = 1'b1;
      tick(1);
      press4(3, 6, 9, 5); pulse_enter();
      check("default_restored", int'(lock), 0);
      pulse_close();
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
